// File: rtl/ram_stream_loader.sv
// rtl/ram_stream_loader.sv - loads bytes into an external 16x8 RAM, then streams them out in address order
module ram_stream_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       start_dump,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       ram_we,
    output logic [3:0] ram_inaddr,
    output logic [7:0] ram_din,
    output logic [3:0] ram_outaddr,
    input  logic [7:0] ram_dout,
    output logic [4:0] level,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic       accept;
    logic       last_word;
    logic [4:0] eff_level;

    assign s_ready     = (state == IDLE) && (level != 5'd16);
    assign accept      = s_valid && s_ready && !rst;
    assign ram_we      = accept;
    assign ram_inaddr  = wr_ptr;
    assign ram_din     = s_data;
    assign ram_outaddr = rd_ptr;
    assign busy        = (state != IDLE);
    // A byte accepted in the same cycle as start_dump belongs to that dump.
    assign eff_level   = level + {4'b0000, accept};
    assign last_word   = ({1'b0, rd_ptr} == (level - 5'd1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_dump && (eff_level != 5'd0)) state_nxt = FETCH;
            FETCH:   state_nxt = SEND;
            SEND:    if (m_ready) state_nxt = last_word ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 4'd0;
            rd_ptr  <= 4'd0;
            level   <= 5'd0;
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 4'd1;
                        level  <= level + 5'd1;
                    end
                    if (start_dump) begin
                        if (eff_level != 5'd0) rd_ptr <= 4'd0;
                        else                   done   <= 1'b1;
                    end
                end
                FETCH: begin
                    m_data  <= ram_dout;
                    m_valid <= 1'b1;
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (last_word) begin
                            done   <= 1'b1;
                            level  <= 5'd0;
                            wr_ptr <= 4'd0;
                        end else begin
                            rd_ptr <= rd_ptr + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
// tb/tb_ram_stream_loader.sv - randomized and directed bench for ram_stream_loader against a queue-based model
module tb_ram_stream_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       start_dump = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       ram_we;
    logic [3:0] ram_inaddr;
    logic [7:0] ram_din;
    logic [3:0] ram_outaddr;
    logic [7:0] ram_dout;
    logic [4:0] level;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    ram_stream_loader dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .start_dump(start_dump),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .ram_we(ram_we), .ram_inaddr(ram_inaddr), .ram_din(ram_din),
        .ram_outaddr(ram_outaddr), .ram_dout(ram_dout),
        .level(level), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    always @(posedge clk) if (ram_we) mem[ram_inaddr] <= ram_din;
    assign ram_dout = mem[ram_outaddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stored bytes are a queue; a dump snapshots it and must come out word by word.
    logic [7:0] mdl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    bit         mdl_busy = 0;
    bit         done_pend = 0;
    int         idx = 0;
    bit         prev_hs = 0;
    bit         prev_hold = 0;
    logic [7:0] prev_data = 8'h00;
    int         stall = 0;
    int         done_seen = 0;
    int         n_writes = 0;

    always @(negedge clk) begin
        bit exp_ready, acc, hs;
        if (rst) begin
            chk("ram_we_in_rst", 32'(ram_we), 32'd0);
            mdl_q.delete();
            exp_q.delete();
            mdl_busy  = 0;
            done_pend = 0;
            idx       = 0;
            prev_hs   = 0;
            prev_hold = 0;
            stall     = 0;
        end else begin
            exp_ready = !mdl_busy && (mdl_q.size() < 16);
            acc       = s_valid && exp_ready;
            chk("busy",    32'(busy),    32'(mdl_busy));
            chk("level",   32'(level),   32'(mdl_q.size()));
            chk("s_ready", 32'(s_ready), 32'(exp_ready));
            chk("ram_we",  32'(ram_we),  32'(acc));
            chk("done",    32'(done),    32'(done_pend));
            if (done) done_seen++;
            if (acc) begin
                chk("ram_inaddr", 32'(ram_inaddr), 32'(mdl_q.size()));
                chk("ram_din",    32'(ram_din),    32'(s_data));
                n_writes++;
            end
            if (!mdl_busy) chk("m_valid_idle", 32'(m_valid), 32'd0);
            if (prev_hs)   chk("m_valid_gap",  32'(m_valid), 32'd0);
            if (prev_hold) begin
                chk("m_valid_hold", 32'(m_valid), 32'd1);
                chk("m_data_hold",  32'(m_data),  32'(prev_data));
            end
            hs = m_valid && m_ready && mdl_busy;
            if (m_valid && mdl_busy) chk("ram_outaddr", 32'(ram_outaddr), 32'(idx));
            if (hs) begin
                if (exp_q.size() == 0) chk("extra_word", 32'(m_valid), 32'd0);
                else begin
                    chk("m_data", 32'(m_data), 32'(exp_q[0]));
                    got.push_back(m_data);
                    void'(exp_q.pop_front());
                    idx++;
                end
            end
            if (mdl_busy && m_ready && !hs) begin
                stall++;
                if (stall > 1) begin
                    chk("stall", 32'(stall), 32'd1);
                    stall = 0;
                end
            end else stall = 0;
            prev_hs   = hs;
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;

            done_pend = 0;
            if (!mdl_busy) begin
                if (acc) mdl_q.push_back(s_data);
                if (start_dump) begin
                    if (mdl_q.size() > 0) begin
                        mdl_busy = 1;
                        exp_q    = mdl_q;
                        idx      = 0;
                    end else done_pend = 1;
                end
            end else if (hs && exp_q.size() == 0) begin
                mdl_busy  = 0;
                mdl_q.delete();
                done_pend = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; s_valid = 0; start_dump = 0; m_ready = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic load(input logic [7:0] b);
        s_valid = 1; s_data = b;
        step();
        s_valid = 0;
    endtask

    task automatic wait_done(input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            step();
            if (done) begin ok = 1; break; end
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic dump();
        start_dump = 1;
        step();
        start_dump = 0;
    endtask

    initial begin
        int base_w, base_d;
        do_reset();
        chk("rst_level",   32'(level),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);

        // three bytes, dump with free-running consumer
        base_w = n_writes;
        s_valid = 1;
        s_data = 8'h11; step();
        s_data = 8'h22; step();
        s_data = 8'h33; step();
        s_valid = 0;
        got.delete();
        m_ready = 1;
        base_d = done_seen;
        dump();
        wait_done(40);
        step();
        chk("t1_writes", 32'(n_writes - base_w), 32'd3);
        chk("t1_count",  32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t1_w0", 32'(got[0]), 32'h11);
            chk("t1_w1", 32'(got[1]), 32'h22);
            chk("t1_w2", 32'(got[2]), 32'h33);
        end
        chk("t1_dones", 32'(done_seen - base_d), 32'd1);
        chk("t1_level", 32'(level), 32'd0);

        // fill to 16, then press on with 0xFF
        do_reset();
        base_w = n_writes;
        for (int i = 0; i < 16; i++) load(8'(i));
        s_valid = 1; s_data = 8'hFF;
        step(); step(); step();
        chk("t2_s_ready", 32'(s_ready), 32'd0);
        chk("t2_level",   32'(level),   32'd16);
        chk("t2_ram_we",  32'(ram_we),  32'd0);
        s_valid = 0;
        chk("t2_writes", 32'(n_writes - base_w), 32'd16);
        got.delete();
        m_ready = 1;
        dump();
        wait_done(80);
        chk("t2_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("t2_word", 32'(got[i]), 32'(i));

        // consumer stalls in SEND
        do_reset();
        load(8'h11); load(8'h22);
        got.delete();
        m_ready = 0;
        dump();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_m_valid", 32'(m_valid),     32'd1);
            chk("t3_m_data",  32'(m_data),      32'h11);
            chk("t3_outaddr", 32'(ram_outaddr), 32'd0);
            step();
        end
        m_ready = 1;
        wait_done(20);
        chk("t3_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) chk("t3_w1", 32'(got[1]), 32'h22);

        // empty dump
        do_reset();
        dump();
        chk("t4_done",    32'(done),    32'd1);
        chk("t4_busy",    32'(busy),    32'd0);
        chk("t4_m_valid", 32'(m_valid), 32'd0);
        step();
        chk("t4_done_off", 32'(done), 32'd0);
        chk("t4_busy2",    32'(busy), 32'd0);

        // accept and start_dump in the same cycle
        do_reset();
        load(8'h55);
        got.delete();
        s_valid = 1; s_data = 8'hAA; start_dump = 1;
        step();
        s_valid = 0; start_dump = 0; m_ready = 1;
        wait_done(20);
        chk("t5_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t5_w0", 32'(got[0]), 32'h55);
            chk("t5_w1", 32'(got[1]), 32'hAA);
        end

        // reset while word 1 of 4 is in SEND
        do_reset();
        for (int i = 0; i < 4; i++) load(8'($urandom));
        m_ready = 0;
        dump();
        step();
        m_ready = 1; step();
        m_ready = 0; step();
        chk("t6_in_send", 32'(m_valid), 32'd1);
        base_d = done_seen;
        rst = 1; step(); rst = 0;
        chk("t6_m_valid", 32'(m_valid), 32'd0);
        chk("t6_level",   32'(level),   32'd0);
        chk("t6_busy",    32'(busy),    32'd0);
        chk("t6_done",    32'(done),    32'd0);
        step();
        chk("t6_no_done", 32'(done_seen - base_d), 32'd0);

        // random traffic, checked cycle by cycle by the model
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            s_valid    = $urandom_range(0, 1) == 1;
            s_data     = 8'($urandom);
            start_dump = ($urandom_range(0, 24) == 0);
            m_ready    = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 0; s_valid = 0; start_dump = 0; m_ready = 1;
        for (int c = 0; c < 60; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_stream_loader.md
RAM_STREAM_LOADER -- requirements
Module: ram_stream_loader

Interface
REQ-001 Parameters SHALL be: none; depth is fixed at 16 words, data width at 8 bits, address width at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_valid  input  1  upstream byte valid.
REQ-005 s_data  input  8  upstream byte.
REQ-006 s_ready  output  1  loader can accept a byte this cycle.
REQ-007 start_dump  input  1  single-cycle request to stream stored words out.
REQ-008 m_valid  output  1  m_data holds a word for the consumer.
REQ-009 m_data  output  8  dumped word, registered.
REQ-010 m_ready  input  1  consumer accepts m_data.
REQ-011 ram_we  output  1  write enable to the 16x8 RAM.
REQ-012 ram_inaddr  output  4  RAM write address.
REQ-013 ram_din  output  8  RAM write data.
REQ-014 ram_outaddr  output  4  RAM read address.
REQ-015 ram_dout  input  8  RAM asynchronous read data for ram_outaddr.
REQ-016 level  output  5  stored word count, 0..16.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse when a dump completes.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, SEND.
REQ-020 s_ready SHALL be 1 only in IDLE with level<16.
REQ-021 Write accept = s_valid & s_ready, with ram_we = accept combinationally, ram_inaddr = wr_ptr, ram_din = s_data, and the RAM write on the same edge.
REQ-022 Each accept SHALL increment wr_ptr (4-bit, wraps 15->0) and level; at level=16, s_ready=0 and further s_valid is ignored (no write, no level change).
REQ-023 IDLE, start_dump=1, level (after any same-cycle accept) >0: rd_ptr<=0, go FETCH.
REQ-024 Simultaneous accept and start_dump in IDLE: the write completes and that byte is included in the dump.
REQ-025 IDLE, start_dump=1, effective level=0: done pulses next cycle, state stays IDLE.
REQ-026 ram_outaddr SHALL equal rd_ptr at all times.
REQ-027 FETCH: m_data<=ram_dout, m_valid<=1, go SEND; 1 cycle.
REQ-028 SEND: m_valid=1 and m_data held stable until m_valid&m_ready.
REQ-029 SEND with m_ready: if rd_ptr==level-1, then m_valid<=0, done<=1 (1 cycle), level<=0, wr_ptr<=0, go IDLE; else rd_ptr++, m_valid<=0, go FETCH.
REQ-030 Throughput SHALL be at most one word per 2 cycles; words SHALL be emitted in address order 0..level-1.
REQ-031 start_dump and s_valid outside IDLE SHALL be ignored; s_ready=0 there.
REQ-032 busy = (state != IDLE).

Reset
REQ-033 rst=1 at an edge: state=IDLE, wr_ptr=0, rd_ptr=0, level=0, m_valid=0, m_data=0x00, done=0; rst has priority over all other inputs.
REQ-034 rst during FETCH/SEND SHALL abort the dump (m_valid low from the next cycle) without writing the RAM; RAM contents are not cleared.
REQ-035 During rst=1, ram_we SHALL be 0.

Verification
REQ-036 Load 0x11,0x22,0x33 back-to-back, then start_dump with m_ready=1 -> ram_we on 3 cycles at addresses 0,1,2; m_data sequence 0x11,0x22,0x33; done pulses once; level returns to 0.
REQ-037 Load 16 bytes 0x00..0x0F, then hold s_valid with 0xFF -> s_ready=0 at level=16, no 17th write; dump yields 0x00..0x0F.
REQ-038 Dump of 2 words with m_ready=0 for 5 cycles in SEND -> m_valid stays 1, m_data stays 0x11, ram_outaddr stays 0, no advance until m_ready=1.
REQ-039 start_dump at level=0 -> no m_valid, done=1 for exactly one cycle, busy stays 0.
REQ-040 s_valid with 0xAA and start_dump in the same IDLE cycle at level=1 (word0=0x55) -> dump emits 0x55, 0xAA.
REQ-041 rst asserted in SEND of word 1 of 4 -> next cycle m_valid=0, level=0, busy=0, no done pulse.
